vga_pattern_gen: RTL and testbench

Parametrised successor to the fixed 800x600 timing plus test-pattern pair. Generates programmable VGA horizontal/vertical timing with configurable sync polarity and colour depth. Produces one of four selectable test patterns on pixel-aligned registered RGB outputs. Sits between the pixel-clock MMCM/BUFGCE and the VGA pins.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_timing_core.sv | 109 ++++++++++
 rtl/vga_pattern_gen.sv | 203 ++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: pattern mode encodings and
// default 800x600@60 timing. Optional build macro: VGA_SCROLL_EN (see vga_pattern_gen).
package vga_pkg;

    localparam logic [1:0] MODE_BORDER  = 2'd0;
    localparam logic [1:0] MODE_BARS    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_SOLID   = 2'd3;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;
    localparam int DEF_CNT_W    = 11;

endpackage

// File: rtl/vga_timing_core.sv
// Stage-0 raster timing: pixel/line counters plus blank, internal (active-high)
// sync and frame_start, all registered from the same next-state so they agree.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             pclk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] hcount_o,
    output logic [CNT_W-1:0] vcount_o,
    output logic             hblnk_o,
    output logic             vblnk_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_start_o,
    output logic             frame_end_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic             run_q;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             fstart_q, fstart_d;

    // Next raster position; the first cycle after reset holds (0,0) so frame_start fires there
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (!run_q) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (hcount_q == H_LAST_C) begin
            hcount_d = '0;
            if (vcount_q == V_LAST_C) begin
                vcount_d = '0;
            end else begin
                vcount_d = vcount_q + CNT_W'(1);
            end
        end else begin
            hcount_d = hcount_q + CNT_W'(1);
        end
    end

    // Decode flags from the next position so they register alongside the counters
    always_comb begin
        hblnk_d  = (hcount_d >= H_ACT_C);
        vblnk_d  = (vcount_d >= V_ACT_C);
        hsync_d  = (hcount_d >= HS_FIRST_C) && (hcount_d <= HS_LAST_C);
        vsync_d  = (vcount_d >= VS_FIRST_C) && (vcount_d <= VS_LAST_C);
        fstart_d = (hcount_d == '0) && (vcount_d == '0);
    end

    // Stage-0 registers
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q    <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fstart_q <= fstart_d;
        end
    end

    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign hblnk_o       = hblnk_q;
    assign vblnk_o       = vblnk_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = fstart_q;
    assign frame_end_o   = run_q && (hcount_q == H_LAST_C) && (vcount_q == V_LAST_C);

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus four selectable test patterns on registered, pixel-aligned RGB/sync.
// Build macro VGA_SCROLL_EN: bars and checker scroll left one pixel per frame.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int COLOR_W    = 4,
    parameter int CHK_LOG2   = 5
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [1:0]         mode,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hblnk,
    output logic               vblnk,
    output logic               frame_start,
    output logic               hs,
    output logic               vs,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    localparam logic HS_ACT_C = 1'(H_SYNC_POL);
    localparam logic VS_ACT_C = 1'(V_SYNC_POL);

    localparam logic [CNT_W-1:0] H_END_C = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_END_C = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR1_C  = CNT_W'((1 * H_ACTIVE) / 8);
    localparam logic [CNT_W-1:0] BAR2_C  = CNT_W'((2 * H_ACTIVE) / 8);
    localparam logic [CNT_W-1:0] BAR3_C  = CNT_W'((3 * H_ACTIVE) / 8);
    localparam logic [CNT_W-1:0] BAR4_C  = CNT_W'((4 * H_ACTIVE) / 8);
    localparam logic [CNT_W-1:0] BAR5_C  = CNT_W'((5 * H_ACTIVE) / 8);
    localparam logic [CNT_W-1:0] BAR6_C  = CNT_W'((6 * H_ACTIVE) / 8);
    localparam logic [CNT_W-1:0] BAR7_C  = CNT_W'((7 * H_ACTIVE) / 8);

    localparam logic [COLOR_W-1:0] GRAY_C = {1'b1, {(COLOR_W-1){1'b0}}};

    logic [CNT_W-1:0] hcount_s, vcount_s, x_s;
    logic             hblnk_s, vblnk_s, hsync_s, vsync_s, fstart_s, fend_s;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       col_s;
    logic             gray_s;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CNT_W    (CNT_W)
    ) u_timing (
        .pclk_i        (pclk),
        .rst_i         (rst),
        .hcount_o      (hcount_s),
        .vcount_o      (vcount_s),
        .hblnk_o       (hblnk_s),
        .vblnk_o       (vblnk_s),
        .hsync_o       (hsync_s),
        .vsync_o       (vsync_s),
        .frame_start_o (fstart_s),
        .frame_end_o   (fend_s)
    );

`ifdef VGA_SCROLL_EN
    localparam logic [CNT_W:0] H_ACT_W_C = (CNT_W+1)'(H_ACTIVE);

    logic [CNT_W-1:0] scroll_q, scroll_d;
    logic [CNT_W:0]   xsum_s;

    // Offset advances on the last pixel of a frame so each frame uses one value
    always_comb begin
        scroll_d = scroll_q;
        if (fend_s) begin
            if (scroll_q == H_END_C) begin
                scroll_d = '0;
            end else begin
                scroll_d = scroll_q + CNT_W'(1);
            end
        end else begin
            scroll_d = scroll_q;
        end
    end

    // Scroll offset register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            scroll_q <= '0;
        end else begin
            scroll_q <= scroll_d;
        end
    end

    // Wrapped scrolled column (single conditional subtract, no divider)
    always_comb begin
        xsum_s = {1'b0, hcount_s} + {1'b0, scroll_q};
        if (xsum_s >= H_ACT_W_C) begin
            x_s = CNT_W'(xsum_s - H_ACT_W_C);
        end else begin
            x_s = xsum_s[CNT_W-1:0];
        end
    end
`else
    assign x_s = hcount_s;
`endif

    // Pattern selection is only allowed to change at the frame boundary
    always_comb begin
        if (fend_s) begin
            mode_d = mode;
        end else begin
            mode_d = mode_q;
        end
    end

    // Pixel colour as on/off flags {r,g,b} plus a gray override
    always_comb begin
        col_s  = 3'b000;
        gray_s = 1'b0;
        if (hblnk_s || vblnk_s) begin
            col_s = 3'b000;
        end else begin
            case (mode_q)
                MODE_BORDER: begin
                    if (vcount_s == '0)           col_s = 3'b110;
                    else if (vcount_s == V_END_C) col_s = 3'b100;
                    else if (hcount_s == '0)      col_s = 3'b010;
                    else if (hcount_s == H_END_C) col_s = 3'b001;
                    else                          gray_s = 1'b1;
                end
                MODE_BARS: begin
                    if (x_s < BAR1_C)      col_s = 3'b111;
                    else if (x_s < BAR2_C) col_s = 3'b110;
                    else if (x_s < BAR3_C) col_s = 3'b011;
                    else if (x_s < BAR4_C) col_s = 3'b010;
                    else if (x_s < BAR5_C) col_s = 3'b101;
                    else if (x_s < BAR6_C) col_s = 3'b100;
                    else if (x_s < BAR7_C) col_s = 3'b001;
                    else                   col_s = 3'b000;
                end
                MODE_CHECKER: col_s = {3{x_s[CHK_LOG2] ^ vcount_s[CHK_LOG2]}};
                MODE_SOLID:   col_s = 3'b111;
                default:      col_s = 3'b000;
            endcase
        end
    end

    // Stage-1 next values: colour expansion and sync polarity
    always_comb begin
        if (gray_s) begin
            r_d = GRAY_C;
            g_d = GRAY_C;
            b_d = GRAY_C;
        end else begin
            r_d = {COLOR_W{col_s[2]}};
            g_d = {COLOR_W{col_s[1]}};
            b_d = {COLOR_W{col_s[0]}};
        end
        hs_d = hsync_s ? HS_ACT_C : ~HS_ACT_C;
        vs_d = vsync_s ? VS_ACT_C : ~VS_ACT_C;
    end

    // Mode latch and stage-1 output registers
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_BORDER;
            hs_q   <= ~HS_ACT_C;
            vs_q   <= ~VS_ACT_C;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            mode_q <= mode_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    assign hcount      = hcount_s;
    assign vcount      = vcount_s;
    assign hblnk       = hblnk_s;
    assign vblnk       = vblnk_s;
    assign frame_start = fstart_s;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a reduced 80x54 raster (64x48 visible),
// hsync active-low and vsync active-high, 8-pixel checker squares.
module tb_vga_pattern_gen;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [10:0] hcount, vcount;
    logic        hblnk, vblnk, frame_start, hs, vs;
    logic [3:0]  r, g, b;

    vga_pattern_gen #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (48), .V_FP (1), .V_SYNC (2), .V_BP (3),
        .H_SYNC_POL (0), .V_SYNC_POL (1),
        .CNT_W (11), .COLOR_W (4), .CHK_LOG2 (3)
    ) dut (
        .pclk (pclk), .rst (rst), .mode (mode),
        .hcount (hcount), .vcount (vcount), .hblnk (hblnk), .vblnk (vblnk),
        .frame_start (frame_start), .hs (hs), .vs (vs),
        .r (r), .g (g), .b (b)
    );

    always #5 pclk = ~pclk;

    // kind 0: stage-0 counters/flags, 1: stage-1 sync/RGB, 2: full reset state
    typedef struct {
        int          at_cyc;
        string       name;
        int          kind;
        logic [10:0] h, v;
        logic        hb, vb, fs, hs, vs;
        logic [3:0]  r, g, b;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Rising edges since reset release; stage-0 at cycle n shows raster index n-1
    always @(posedge pclk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic exp0(input int at, input string nm, input int h, input int v,
                        input logic hb_e, input logic vb_e, input logic fs_e);
        exp_t e;
        e.at_cyc = at; e.name = nm; e.kind = 0;
        e.h = 11'(h); e.v = 11'(v); e.hb = hb_e; e.vb = vb_e; e.fs = fs_e;
        e.hs = 1'b0; e.vs = 1'b0; e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
        sb_q.push_back(e);
    endtask

    // Pixel (h,v) of frame f reaches stage 1 at cycle f*4320 + v*80 + h + 2
    task automatic exp1(input int f, input int h, input int v, input string nm,
                        input logic hs_e, input logic vs_e,
                        input logic [3:0] r_e, input logic [3:0] g_e, input logic [3:0] b_e);
        exp_t e;
        e.at_cyc = f * 4320 + v * 80 + h + 2; e.name = nm; e.kind = 1;
        e.h = 11'd0; e.v = 11'd0; e.hb = 1'b0; e.vb = 1'b0; e.fs = 1'b0;
        e.hs = hs_e; e.vs = vs_e; e.r = r_e; e.g = g_e; e.b = b_e;
        sb_q.push_back(e);
    endtask

    task automatic exp_rst(input string nm);
        exp_t e;
        e.at_cyc = 0; e.name = nm; e.kind = 2;
        e.h = 11'd0; e.v = 11'd0; e.hb = 1'b0; e.vb = 1'b0; e.fs = 1'b0;
        e.hs = 1'b1; e.vs = 1'b0; e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
        sb_q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        int guard = 0;
        while (cyc < n && guard < 50000) begin
            @(negedge pclk);
            guard++;
        end
        #1;
    endtask

    // Monitor: compare every entry whose cycle has arrived, away from the active edge
    initial begin
        exp_t e;
        bit   ok0, ok1;
        forever begin
            @(negedge pclk);
            while (sb_q.size() > 0 && sb_q[0].at_cyc <= cyc) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (e.at_cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: check skipped, now cycle %0d, required cycle %0d", e.name, cyc, e.at_cyc);
                end else begin
                    ok0 = (hcount === e.h) && (vcount === e.v) && (hblnk === e.hb) &&
                          (vblnk === e.vb) && (frame_start === e.fs);
                    ok1 = (hs === e.hs) && (vs === e.vs) && (r === e.r) && (g === e.g) && (b === e.b);
                    if ((e.kind != 1 && !ok0) || (e.kind != 0 && !ok1)) begin
                        n_bad++;
                        $display("FAIL %s @%0d: got h=%0d v=%0d hb=%b vb=%b fs=%b hs=%b vs=%b rgb=%h%h%h, required h=%0d v=%0d hb=%b vb=%b fs=%b hs=%b vs=%b rgb=%h%h%h (kind %0d)",
                                 e.name, cyc, hcount, vcount, hblnk, vblnk, frame_start, hs, vs, r, g, b,
                                 e.h, e.v, e.hb, e.vb, e.fs, e.hs, e.vs, e.r, e.g, e.b, e.kind);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        exp_rst("reset_state");
        repeat (3) @(negedge pclk);
        #1 rst = 1'b0;

        exp0(1,    "s0_first_fs",   0,  0, 1'b0, 1'b0, 1'b1);
        exp0(2,    "s0_h1",         1,  0, 1'b0, 1'b0, 1'b0);
        exp1(0,  0,  0, "brd_00_yel",  1'b1, 1'b0, 4'hF, 4'hF, 4'h0);
        exp0(64,   "s0_h63_noblnk", 63, 0, 1'b0, 1'b0, 1'b0);
        exp0(65,   "s0_h64_hblnk",  64, 0, 1'b1, 1'b0, 1'b0);
        exp0(80,   "s0_h79",        79, 0, 1'b1, 1'b0, 1'b0);
        exp0(81,   "s0_hwrap",      0,  1, 1'b0, 1'b0, 1'b0);
        exp1(0,  0,  5, "brd_left_grn", 1'b1, 1'b0, 4'h0, 4'hF, 4'h0);
        exp1(0, 63,  5, "brd_right_blu",1'b1, 1'b0, 4'h0, 4'h0, 4'hF);
        exp1(0, 66, 10, "hfp_blank",    1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        exp1(0, 67, 10, "hs_before",    1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        exp1(0, 68, 10, "hs_first",     1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        exp1(0, 75, 10, "hs_last",      1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        exp1(0, 76, 10, "hs_after",     1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        exp1(0, 32, 24, "brd_mid_gray", 1'b1, 1'b0, 4'h8, 4'h8, 4'h8);
        exp1(0, 40, 30, "brd_after_modechg", 1'b1, 1'b0, 4'h8, 4'h8, 4'h8);
        exp1(0,  5, 47, "brd_bottom_red",    1'b1, 1'b0, 4'hF, 4'h0, 4'h0);
        exp0(3841, "s0_vblnk",      0, 48, 1'b0, 1'b1, 1'b0);
        exp1(0,  0, 48, "vs_before",    1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        exp1(0,  0, 49, "vs_first",     1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        exp1(0, 79, 50, "vs_last",      1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        exp1(0,  0, 51, "vs_after",     1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        exp0(4320, "s0_last",       79, 53, 1'b1, 1'b1, 1'b0);
        exp0(4321, "s0_fs_frame1",  0,  0, 1'b0, 1'b0, 1'b1);
        exp1(1,  0,  0, "bars_00_white", 1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
        exp1(1,  0,  1, "bars_white",    1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
        exp1(1,  8,  1, "bars_yellow",   1'b1, 1'b0, 4'hF, 4'hF, 4'h0);
`ifdef VGA_SCROLL_EN
        exp1(1, 63,  1, "bars_last_scrolled_white", 1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
`else
        exp1(1, 63,  1, "bars_last_black", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
`endif
        exp1(1, 20,  2, "bars_cyan",     1'b1, 1'b0, 4'h0, 4'hF, 4'hF);
        exp1(1, 28,  2, "bars_green",    1'b1, 1'b0, 4'h0, 4'hF, 4'h0);
        exp1(1, 36,  2, "bars_magenta",  1'b1, 1'b0, 4'hF, 4'h0, 4'hF);
        exp1(1, 44,  2, "bars_red",      1'b1, 1'b0, 4'hF, 4'h0, 4'h0);
        exp1(1, 52,  2, "bars_blue",     1'b1, 1'b0, 4'h0, 4'h0, 4'hF);
        exp0(8641, "s0_fs_frame2",  0,  0, 1'b0, 1'b0, 1'b1);
`ifdef VGA_SCROLL_EN
        exp1(2,  7,  0, "chk_7_0_scrolled_white", 1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
`else
        exp1(2,  7,  0, "chk_7_0_black", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
`endif
        exp1(2,  8,  0, "chk_8_0_white", 1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
        exp1(2,  0,  8, "chk_0_8_white", 1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
        exp1(2,  8,  8, "chk_8_8_black", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        exp1(3, 30, 20, "solid_white",   1'b1, 1'b0, 4'hF, 4'hF, 4'hF);
        exp1(3, 70, 20, "solid_hblank",  1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        wait_until(1955);  mode = 2'd1;
        wait_until(4600);  mode = 2'd2;
        wait_until(9300);  mode = 2'd3;
        // Stage-0 sits at (50,30) of frame 3 here
        wait_until(15411);
        rst = 1'b1;
        exp_rst("midframe_reset");
        repeat (3) @(negedge pclk);
        #1 rst = 1'b0;
        exp0(1, "restart_fs",  0, 0, 1'b0, 1'b0, 1'b1);
        exp0(2, "restart_h1",  1, 0, 1'b0, 1'b0, 1'b0);
        exp1(0, 0, 0, "restart_mode_border", 1'b1, 1'b0, 4'hF, 4'hF, 4'h0);

        guard = 0;
        while (sb_q.size() > 0 && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        #1;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d checks pending, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
